wb_slave_mem: RTL and testbench

Wishbone slave memory responder, 64-bit data, byte-addressed: the RTL target that answers transfers arriving on the slave-side Wishbone bus our slave agent monitors and drives. Decodes the address window, applies programmable wait states, performs byte-laned writes and word reads on an internal array, and returns ACK_O, ERR_O or RTY_O with echoed data tags. Single-beat classic cycles only; no bursts.

---
 rtl/wb_slave_mem.sv | 137 +++++++++++++
 tb/tb_wb_slave_mem.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/wb_slave_mem.sv
// Wishbone classic single-beat slave over a 64-bit word array with programmable wait states.
// Optional retry/busy behaviour is enabled with `define WB_SLAVE_MEM_RETRY_EN.
module wb_slave_mem #(
   parameter int          ADDR_WIDTH  = 8,
   parameter logic [63:0] BASE_ADDR   = 64'h0,
   parameter int          WAIT_STATES = 1,
   parameter int          BUSY_CYCLES = 2
) (
   input  logic        clk,
   input  logic        RST_I,
   input  logic        CYC_I,
   input  logic        STB_I,
   input  logic        WE_I,
   input  logic [63:0] ADR_I,
   input  logic [7:0]  SEL_I,
   input  logic [63:0] DAT_I,
   input  logic [15:0] TGD_I,
   output logic [63:0] DAT_O,
   output logic [15:0] TGD_O,
   output logic        ACK_O,
   output logic        ERR_O,
   output logic        RTY_O
);

   localparam logic [3:0] WS = 4'(WAIT_STATES);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t                state;
   logic [3:0]            wcnt;
   logic                  we_q;
   logic [63:0]           adr_q;
   logic [7:0]            sel_q;
   logic [63:0]           dat_q;
   logic [15:0]           tgd_q;
   logic [63:0]           mem [0:(1<<ADDR_WIDTH)-1];

   logic                  resp_prev;
   logic                  hit;
   logic [ADDR_WIDTH-1:0] idx;
   logic                  busy_nz;
   logic                  retry_q;

   // A response in the previous cycle forces one turnaround cycle before the next accept.
   assign resp_prev = ACK_O | ERR_O | RTY_O;
   assign hit = (adr_q[2:0] == 3'b000) &&
                (adr_q[63:3+ADDR_WIDTH] == BASE_ADDR[63:3+ADDR_WIDTH]);
   assign idx = adr_q[3+ADDR_WIDTH-1:3];

`ifdef WB_SLAVE_MEM_RETRY_EN
   localparam logic [3:0] BC = 4'(BUSY_CYCLES);
   logic [3:0] busy;
   assign busy_nz = (busy != 4'd0);
`else
   assign busy_nz = 1'b0;
   assign RTY_O   = 1'b0;
`endif

   always_ff @(posedge clk or posedge RST_I) begin
      if (RST_I) begin
         state   <= IDLE;
         wcnt    <= 4'd0;
         we_q    <= 1'b0;
         adr_q   <= 64'h0;
         sel_q   <= 8'h0;
         dat_q   <= 64'h0;
         tgd_q   <= 16'h0;
         retry_q <= 1'b0;
         ACK_O   <= 1'b0;
         ERR_O   <= 1'b0;
         DAT_O   <= 64'h0;
         TGD_O   <= 16'h0;
`ifdef WB_SLAVE_MEM_RETRY_EN
         RTY_O   <= 1'b0;
         busy    <= 4'd0;
`endif
      end else begin
         ACK_O <= 1'b0;
         ERR_O <= 1'b0;
         DAT_O <= 64'h0;
         TGD_O <= 16'h0;
`ifdef WB_SLAVE_MEM_RETRY_EN
         RTY_O <= 1'b0;
         if (busy_nz) busy <= busy - 4'd1;
`endif
         case (state)
            IDLE: begin
               if (CYC_I && STB_I && !resp_prev) begin
                  we_q    <= WE_I;
                  adr_q   <= ADR_I;
                  sel_q   <= SEL_I;
                  dat_q   <= DAT_I;
                  tgd_q   <= TGD_I;
                  retry_q <= busy_nz;
                  wcnt    <= WS;
                  // A busy accept skips the wait states and retries immediately.
                  state   <= (busy_nz || WS == 4'd0) ? RESP : WAIT;
               end
            end
            WAIT: begin
               wcnt <= wcnt - 4'd1;
               if (!CYC_I)
                  state <= IDLE;
               else if (wcnt == 4'd1)
                  state <= RESP;
            end
            RESP: begin
               state <= IDLE;
               TGD_O <= tgd_q;
               if (retry_q) begin
`ifdef WB_SLAVE_MEM_RETRY_EN
                  RTY_O <= 1'b1;
`endif
               end else if (!hit) begin
                  ERR_O <= 1'b1;
               end else begin
                  ACK_O <= 1'b1;
                  if (!we_q) DAT_O <= mem[idx];
`ifdef WB_SLAVE_MEM_RETRY_EN
                  busy <= BC;
`endif
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Array is deliberately not reset; writes land on the same edge the ACK is registered.
   always_ff @(posedge clk) begin
      if (!RST_I && state == RESP && hit && we_q && !retry_q) begin
         for (int i = 0; i < 8; i++)
            if (sel_q[i]) mem[idx][8*i +: 8] <= dat_q[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_wb_slave_mem.sv
// Directed self-checking bench for wb_slave_mem: three instances with WAIT_STATES 1, 3 and 0.
module tb_wb_slave_mem;

   logic        clk = 1'b0;
   logic        rst;
   logic        cyc1, cyc3, cyc0;
   logic        stb, we;
   logic [63:0] adr, dat;
   logic [7:0]  sel;
   logic [15:0] tgd;

   logic [63:0] dat1, dat3, dat0;
   logic [15:0] tgd1, tgd3, tgd0;
   logic        ack1, err1, rty1, ack3, err3, rty3, ack0, err0, rty0;

   int n_tests = 0;
   int n_fail  = 0;
   int gap     = 0;

   localparam logic [2:0] T_ACK = 3'b100, T_ERR = 3'b010, T_RTY = 3'b001, T_NONE = 3'b000;

   always #5 clk = ~clk;

   wb_slave_mem #(.WAIT_STATES(1), .BUSY_CYCLES(4)) u1 (
      .clk(clk), .RST_I(rst), .CYC_I(cyc1), .STB_I(stb), .WE_I(we), .ADR_I(adr),
      .SEL_I(sel), .DAT_I(dat), .TGD_I(tgd), .DAT_O(dat1), .TGD_O(tgd1),
      .ACK_O(ack1), .ERR_O(err1), .RTY_O(rty1));

   wb_slave_mem #(.WAIT_STATES(3)) u3 (
      .clk(clk), .RST_I(rst), .CYC_I(cyc3), .STB_I(stb), .WE_I(we), .ADR_I(adr),
      .SEL_I(sel), .DAT_I(dat), .TGD_I(tgd), .DAT_O(dat3), .TGD_O(tgd3),
      .ACK_O(ack3), .ERR_O(err3), .RTY_O(rty3));

   wb_slave_mem #(.WAIT_STATES(0)) u0 (
      .clk(clk), .RST_I(rst), .CYC_I(cyc0), .STB_I(stb), .WE_I(we), .ADR_I(adr),
      .SEL_I(sel), .DAT_I(dat), .TGD_I(tgd), .DAT_O(dat0), .TGD_O(tgd0),
      .ACK_O(ack0), .ERR_O(err0), .RTY_O(rty0));

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic samp(input int inst, output logic [2:0] term, output logic [63:0] rd,
                       output logic [15:0] tg);
      case (inst)
         1:       begin term = {ack1, err1, rty1}; rd = dat1; tg = tgd1; end
         3:       begin term = {ack3, err3, rty3}; rd = dat3; tg = tgd3; end
         default: begin term = {ack0, err0, rty0}; rd = dat0; tg = tgd0; end
      endcase
   endtask

   task automatic idle_bus();
      cyc1 = 1'b0; cyc3 = 1'b0; cyc0 = 1'b0; stb = 1'b0;
   endtask

   task automatic drive(input int inst, input logic w, input logic [63:0] a, input logic [7:0] s,
                        input logic [63:0] d, input logic [15:0] t);
      @(negedge clk);
      we = w; adr = a; sel = s; dat = d; tgd = t; stb = 1'b1;
      cyc1 = (inst == 1); cyc3 = (inst == 3); cyc0 = (inst == 0);
   endtask

   // One transfer: checks termination kind, latency from accept edge, read data and echoed tag.
   task automatic xfer(input string tag, input int inst, input logic w, input logic [63:0] a,
                       input logic [7:0] s, input logic [63:0] d, input logic [15:0] t,
                       input logic [2:0] exp_term, input int exp_lat, input logic [63:0] exp_rd);
      logic [2:0]  term;
      logic [63:0] rd;
      logic [15:0] tg;
      int          lat;
      lat = 0;
      term = T_NONE; rd = '0; tg = '0;
      drive(inst, w, a, s, d, t);
      @(posedge clk);
      for (int i = 1; i <= 20; i++) begin
         @(posedge clk); #1;
         samp(inst, term, rd, tg);
         if (term != T_NONE) begin
            lat = i;
            break;
         end
      end
      idle_bus();
      chk({tag, "_term"}, 64'(term), 64'(exp_term));
      chk({tag, "_lat"},  64'(lat),  64'(exp_lat));
      chk({tag, "_dat"},  rd,        exp_rd);
      chk({tag, "_tgd"},  64'(tg),   64'(t));
      @(posedge clk); #1;
      samp(inst, term, rd, tg);
      chk({tag, "_turn"}, {term, rd, tg} == '0 ? 64'd0 : 64'd1, 64'd0);
      repeat (gap) @(posedge clk);
   endtask

   initial begin
      logic [2:0]  term;
      logic [63:0] rd;
      logic [15:0] tg;
      int          quiet;

`ifdef WB_SLAVE_MEM_RETRY_EN
      gap = 6;
`endif
      rst = 1'b1;
      we = 1'b0; adr = '0; sel = '0; dat = '0; tgd = '0;
      idle_bus();
      #1;
      chk("reset_u1", {ack1, err1, rty1, dat1, tgd1} == '0 ? 64'd0 : 64'd1, 64'd0);
      chk("reset_u3", {ack3, err3, rty3, dat3, tgd3} == '0 ? 64'd0 : 64'd1, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Basic write/read, byte lanes, SEL=0 write, errors (both alias word index 0).
      xfer("wr10",   1, 1'b1, 64'h10,  8'hFF, 64'hDEADBEEF_01234567, 16'hA5A5, T_ACK, 2, 64'h0);
      xfer("rd10",   1, 1'b0, 64'h10,  8'h00, 64'h0, 16'h1234, T_ACK, 2, 64'hDEADBEEF_01234567);
      xfer("wr18a",  1, 1'b1, 64'h18,  8'hFF, 64'hFFFFFFFF_FFFFFFFF, 16'h0001, T_ACK, 2, 64'h0);
      xfer("wr18b",  1, 1'b1, 64'h18,  8'h0F, 64'h0, 16'h0002, T_ACK, 2, 64'h0);
      xfer("rd18",   1, 1'b0, 64'h18,  8'h00, 64'h0, 16'h0003, T_ACK, 2, 64'hFFFFFFFF_00000000);
      xfer("wr18z",  1, 1'b1, 64'h18,  8'h00, 64'h0, 16'h0004, T_ACK, 2, 64'h0);
      xfer("rd18z",  1, 1'b0, 64'h18,  8'hFF, 64'h0, 16'h0005, T_ACK, 2, 64'hFFFFFFFF_00000000);
      xfer("wr00",   1, 1'b1, 64'h0,   8'hFF, 64'h0, 16'h0006, T_ACK, 2, 64'h0);
      xfer("mis803", 1, 1'b1, 64'h803, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 16'h0BAD, T_ERR, 2, 64'h0);
      xfer("win800", 1, 1'b1, 64'h800, 8'hFF, 64'hFFFFFFFF_FFFFFFFF, 16'h0C0C, T_ERR, 2, 64'h0);
      xfer("rdwin",  1, 1'b0, 64'h800, 8'hFF, 64'h0, 16'h0C0D, T_ERR, 2, 64'h0);
      xfer("rd00",   1, 1'b0, 64'h0,   8'hFF, 64'h0, 16'h0007, T_ACK, 2, 64'h0);
      xfer("rd10b",  1, 1'b0, 64'h10,  8'hFF, 64'h0, 16'h0008, T_ACK, 2, 64'hDEADBEEF_01234567);

      // Abort on WAIT_STATES=3: CYC dropped after E0+2, write must not happen.
      xfer("u3wr",   3, 1'b1, 64'h20,  8'hFF, 64'h11112222_33334444, 16'h3333, T_ACK, 4, 64'h0);
      drive(3, 1'b1, 64'h20, 8'hFF, 64'h55556666_77778888, 16'h4444);
      quiet = 1;
      for (int i = 0; i <= 2; i++) begin
         @(posedge clk); #1;
         samp(3, term, rd, tg);
         if (term != T_NONE) quiet = 0;
      end
      idle_bus();
      repeat (6) begin
         @(posedge clk); #1;
         samp(3, term, rd, tg);
         if (term != T_NONE) quiet = 0;
      end
      chk("abort_quiet", 64'(quiet), 64'd1);
      xfer("u3rd",   3, 1'b0, 64'h20,  8'hFF, 64'h0, 16'h3334, T_ACK, 4, 64'h11112222_33334444);

      // Reset during WAIT, then a clean transfer.
      drive(3, 1'b1, 64'h20, 8'hFF, 64'h99999999_99999999, 16'h5555);
      @(posedge clk);
      @(posedge clk); #2;
      rst = 1'b1;
      #1;
      chk("rst_wait", {ack3, err3, rty3, dat3, tgd3} == '0 ? 64'd0 : 64'd1, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      idle_bus();
      xfer("u3rst",  3, 1'b0, 64'h20,  8'hFF, 64'h0, 16'h3335, T_ACK, 4, 64'h11112222_33334444);

      // Asynchronous clear of a live ACK pulse.
      drive(1, 1'b0, 64'h10, 8'hFF, 64'h0, 16'h7777);
      @(posedge clk);
      @(posedge clk);
      @(posedge clk); #1;
      chk("ack_live", {ack1, tgd1}, {47'd0, 1'b1, 16'h7777});
      #2 rst = 1'b1;
      #1;
      chk("rst_async", {ack1, err1, rty1, dat1, tgd1} == '0 ? 64'd0 : 64'd1, 64'd0);
      @(negedge clk);
      rst = 1'b0;
      idle_bus();
      xfer("postrst", 1, 1'b0, 64'h10, 8'hFF, 64'h0, 16'h7778, T_ACK, 2, 64'hDEADBEEF_01234567);

      // WAIT_STATES=0 with STB held: terminations every third cycle, never adjacent.
      drive(0, 1'b0, 64'h10, 8'hFF, 64'h0, 16'h0F0F);
      for (int i = 0; i <= 12; i++) begin
         @(posedge clk); #1;
         if (i > 0) chk($sformatf("b2b_%0d", i), 64'(ack0 | err0 | rty0), 64'(i % 3 == 1));
      end
      idle_bus();
      @(posedge clk);

`ifdef WB_SLAVE_MEM_RETRY_EN
      // Retry: access immediately after turnaround hits the busy window.
      repeat (6) @(posedge clk);
      gap = 0;
      xfer("rty_wr", 1, 1'b1, 64'h28, 8'hFF, 64'hCAFEF00D_00000001, 16'h0A0A, T_ACK, 2, 64'h0);
      xfer("rty_rd", 1, 1'b0, 64'h28, 8'hFF, 64'h0, 16'h0B0B, T_RTY, 1, 64'h0);
      repeat (4) @(posedge clk);
      xfer("rty_ok", 1, 1'b0, 64'h28, 8'hFF, 64'h0, 16'h0C0C, T_ACK, 2, 64'hCAFEF00D_00000001);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
